// File: rtl/agu_ctrl_pkg.sv
// Shared constants for the address-generation stage: widths, access sizes and FSM states.
package agu_ctrl_pkg;

    localparam int XLEN    = 32;
    localparam int PC_SIZE = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        AGU_IDLE = 2'b00,
        AGU_MEM  = 2'b01,
        AGU_WBCK = 2'b10
    } agu_state_e;

endpackage

// File: rtl/agu_addr_calc.sv
// Combinational address/lane calculation: effective address, byte-lane mask,
// replicated store data, misalignment and illegal-operation detection.
module agu_addr_calc
    import agu_ctrl_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int PC_SIZE_P = PC_SIZE
) (
    input  logic                   load,
    input  logic                   store,
    input  logic [1:0]             size,
    input  logic [XLEN_P-1:0]      rs1,
    input  logic [XLEN_P-1:0]      imm,
    input  logic [XLEN_P-1:0]      rs2,
    output logic [PC_SIZE_P-1:0]   addr,
    output logic [XLEN_P-1:0]      wdata,
    output logic [XLEN_P/8-1:0]    wmask,
    output logic                   misalgn,
    output logic                   illegal
);

    localparam int LANES = XLEN_P / 8;
    localparam int LB    = $clog2(LANES);

    logic [XLEN_P-1:0] sum;

    // Carry out of the top bit is dropped so the address wraps modulo 2^PC_SIZE.
    assign sum  = rs1 + imm;
    assign addr = sum[PC_SIZE_P-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wdata[gi*8 +: 8] = (size == SIZE_B) ? rs2[7:0] :
                                      (size == SIZE_H) ? rs2[(gi%2)*8 +: 8] :
                                                         rs2[gi*8 +: 8];
            assign wmask[gi] = (size == SIZE_B) ? (addr[LB-1:0] == LB'(gi)) :
                               (size == SIZE_H) ? (addr[LB-1:1] == (LB-1)'(gi/2)) :
                                                  (size == SIZE_W);
        end
    endgenerate

    assign misalgn = ((size == SIZE_H) & addr[0]) | ((size == SIZE_W) & (|addr[1:0]));
    assign illegal = (size == 2'b11) | (load == store);

endmodule

// File: rtl/agu_ctrl.sv
// Load/store request stage: accepts one op, issues it to memory, returns one writeback record.
// Optional same-cycle accept on writeback handshake is enabled by defining AGU_BYPASS_EN.
module agu_ctrl
    import agu_ctrl_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int PC_SIZE_P = PC_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 exu_i_valid,
    output logic                 exu_o_ready,
    input  logic                 exu_i_load,
    input  logic                 exu_i_store,
    input  logic                 exu_i_usign,
    input  logic [1:0]           exu_i_size,
    input  logic [XLEN_P-1:0]    exu_i_rs1,
    input  logic [XLEN_P-1:0]    exu_i_imm,
    input  logic [XLEN_P-1:0]    exu_i_rs2,
    input  logic [4:0]           exu_i_rd_idx,
    output logic                 agu_o_cmd_enable,
    output logic                 agu_o_cmd_read,
    output logic                 agu_o_cmd_write,
    output logic                 agu_o_cmd_usign,
    output logic [1:0]           agu_o_cmd_size,
    output logic [PC_SIZE_P-1:0] agu_o_cmd_addr,
    output logic [XLEN_P-1:0]    agu_o_cmd_wdata,
    output logic [XLEN_P/8-1:0]  agu_o_cmd_wmask,
    output logic                 agu_o_cmd_misalgn,
    output logic                 agu_o_valid,
    input  logic                 agu_i_ready,
    input  logic [XLEN_P-1:0]    agu_i_wbck_wdata,
    input  logic                 agu_i_wbck_err,
    output logic                 wbck_o_valid,
    input  logic                 wbck_i_ready,
    output logic [XLEN_P-1:0]    wbck_o_wdata,
    output logic [4:0]           wbck_o_rd_idx,
    output logic                 wbck_o_we,
    output logic                 wbck_o_err
);

    agu_state_e state_q, state_d;

    logic                 enable_q, enable_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic                 usign_q, usign_d;
    logic [1:0]           size_q, size_d;
    logic [PC_SIZE_P-1:0] addr_q, addr_d;
    logic [XLEN_P-1:0]    wdata_q, wdata_d;
    logic [XLEN_P/8-1:0]  wmask_q, wmask_d;
    logic                 misalgn_q, misalgn_d;
    logic [4:0]           rd_idx_q, rd_idx_d;
    logic [XLEN_P-1:0]    wb_wdata_q, wb_wdata_d;
    logic                 wb_err_q, wb_err_d;
    logic                 wb_we_q, wb_we_d;

    logic [PC_SIZE_P-1:0] calc_addr;
    logic [XLEN_P-1:0]    calc_wdata;
    logic [XLEN_P/8-1:0]  calc_wmask;
    logic                 calc_misalgn;
    logic                 calc_illegal;
    logic                 accept;

    agu_addr_calc #(
        .XLEN_P    (XLEN_P),
        .PC_SIZE_P (PC_SIZE_P)
    ) u_addr_calc (
        .load    (exu_i_load),
        .store   (exu_i_store),
        .size    (exu_i_size),
        .rs1     (exu_i_rs1),
        .imm     (exu_i_imm),
        .rs2     (exu_i_rs2),
        .addr    (calc_addr),
        .wdata   (calc_wdata),
        .wmask   (calc_wmask),
        .misalgn (calc_misalgn),
        .illegal (calc_illegal)
    );

`ifdef AGU_BYPASS_EN
    assign exu_o_ready = (state_q == AGU_IDLE) | ((state_q == AGU_WBCK) & wbck_i_ready);
`else
    assign exu_o_ready = (state_q == AGU_IDLE);
`endif

    assign accept = exu_i_valid & exu_o_ready;

    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        read_d     = read_q;
        write_d    = write_q;
        usign_d    = usign_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        misalgn_d  = misalgn_q;
        rd_idx_d   = rd_idx_q;
        wb_wdata_d = wb_wdata_q;
        wb_err_d   = wb_err_q;
        wb_we_d    = wb_we_q;

        case (state_q)
            AGU_IDLE: ;
            AGU_MEM: begin
                if (agu_i_ready) begin
                    wb_wdata_d = read_q ? agu_i_wbck_wdata : '0;
                    wb_err_d   = agu_i_wbck_err;
                    wb_we_d    = read_q & ~agu_i_wbck_err;
                    state_d    = AGU_WBCK;
                end
            end
            AGU_WBCK: begin
                if (wbck_i_ready) begin
                    state_d = AGU_IDLE;
                end
            end
            default: state_d = AGU_IDLE;
        endcase

        // Accept overrides the WBCK exit so a bypassed op lands straight in MEM/WBCK.
        if (accept) begin
            enable_d  = 1'b1;
            read_d    = exu_i_load;
            write_d   = exu_i_store;
            usign_d   = exu_i_usign;
            size_d    = exu_i_size;
            addr_d    = calc_addr;
            wdata_d   = calc_wdata;
            wmask_d   = calc_wmask;
            misalgn_d = calc_misalgn;
            rd_idx_d  = exu_i_rd_idx;
            if (calc_misalgn | calc_illegal) begin
                wb_wdata_d = '0;
                wb_err_d   = 1'b1;
                wb_we_d    = 1'b0;
                state_d    = AGU_WBCK;
            end else begin
                state_d = AGU_MEM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= AGU_IDLE;
            enable_q   <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            usign_q    <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            misalgn_q  <= 1'b0;
            rd_idx_q   <= '0;
            wb_wdata_q <= '0;
            wb_err_q   <= 1'b0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            read_q     <= read_d;
            write_q    <= write_d;
            usign_q    <= usign_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            misalgn_q  <= misalgn_d;
            rd_idx_q   <= rd_idx_d;
            wb_wdata_q <= wb_wdata_d;
            wb_err_q   <= wb_err_d;
            wb_we_q    <= wb_we_d;
        end
    end

    assign agu_o_valid       = (state_q == AGU_MEM);
    assign wbck_o_valid      = (state_q == AGU_WBCK);
    assign agu_o_cmd_enable  = enable_q;
    assign agu_o_cmd_read    = read_q;
    assign agu_o_cmd_write   = write_q;
    assign agu_o_cmd_usign   = usign_q;
    assign agu_o_cmd_size    = size_q;
    assign agu_o_cmd_addr    = addr_q;
    assign agu_o_cmd_wdata   = wdata_q;
    assign agu_o_cmd_wmask   = wmask_q;
    assign agu_o_cmd_misalgn = misalgn_q;
    assign wbck_o_wdata      = wb_wdata_q;
    assign wbck_o_rd_idx     = rd_idx_q;
    assign wbck_o_we         = wb_we_q;
    assign wbck_o_err        = wb_err_q;

endmodule

// File: tb/tb_agu_ctrl.sv
// Directed plus randomized bench for agu_ctrl against a behavioural load/store model.
module tb_agu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_i_valid, exu_o_ready;
    logic        exu_i_load, exu_i_store, exu_i_usign;
    logic [1:0]  exu_i_size;
    logic [31:0] exu_i_rs1, exu_i_imm, exu_i_rs2;
    logic [4:0]  exu_i_rd_idx;
    logic        agu_o_cmd_enable, agu_o_cmd_read, agu_o_cmd_write, agu_o_cmd_usign;
    logic [1:0]  agu_o_cmd_size;
    logic [31:0] agu_o_cmd_addr, agu_o_cmd_wdata;
    logic [3:0]  agu_o_cmd_wmask;
    logic        agu_o_cmd_misalgn, agu_o_valid, agu_i_ready;
    logic [31:0] agu_i_wbck_wdata;
    logic        agu_i_wbck_err;
    logic        wbck_o_valid, wbck_i_ready;
    logic [31:0] wbck_o_wdata;
    logic [4:0]  wbck_o_rd_idx;
    logic        wbck_o_we, wbck_o_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    agu_ctrl dut (
        .clk(clk), .rst(rst),
        .exu_i_valid(exu_i_valid), .exu_o_ready(exu_o_ready),
        .exu_i_load(exu_i_load), .exu_i_store(exu_i_store), .exu_i_usign(exu_i_usign),
        .exu_i_size(exu_i_size), .exu_i_rs1(exu_i_rs1), .exu_i_imm(exu_i_imm),
        .exu_i_rs2(exu_i_rs2), .exu_i_rd_idx(exu_i_rd_idx),
        .agu_o_cmd_enable(agu_o_cmd_enable), .agu_o_cmd_read(agu_o_cmd_read),
        .agu_o_cmd_write(agu_o_cmd_write), .agu_o_cmd_usign(agu_o_cmd_usign),
        .agu_o_cmd_size(agu_o_cmd_size), .agu_o_cmd_addr(agu_o_cmd_addr),
        .agu_o_cmd_wdata(agu_o_cmd_wdata), .agu_o_cmd_wmask(agu_o_cmd_wmask),
        .agu_o_cmd_misalgn(agu_o_cmd_misalgn), .agu_o_valid(agu_o_valid),
        .agu_i_ready(agu_i_ready), .agu_i_wbck_wdata(agu_i_wbck_wdata),
        .agu_i_wbck_err(agu_i_wbck_err),
        .wbck_o_valid(wbck_o_valid), .wbck_i_ready(wbck_i_ready),
        .wbck_o_wdata(wbck_o_wdata), .wbck_o_rd_idx(wbck_o_rd_idx),
        .wbck_o_we(wbck_o_we), .wbck_o_err(wbck_o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derived from access-size arithmetic, not lane logic.
    function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [31:0] a);
        case (sz)
            2'd0:    return 4'(1 << (a % 4));
            2'd1:    return 4'(3 << (a & 2));
            2'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] b, h;
        b = {24'h0, d[7:0]};
        h = {16'h0, d[15:0]};
        case (sz)
            2'd0:    return b * 32'h0101_0101;
            2'd1:    return h * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic m_bad(input logic ld, input logic st, input logic [1:0] sz,
                                   input logic [31:0] a);
        if (sz == 2'd3 || ld == st) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    task automatic run_txn(input logic ld, input logic st, input logic us, input logic [1:0] sz,
                           input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                           input logic [4:0] rd, input int mem_wait, input int wb_wait,
                           input logic [31:0] rdata, input logic merr);
        int n;
        logic [31:0] ea;
        logic bad;
        n = 0;
        while (exu_o_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("exu_ready_idle", exu_o_ready, 1);
        exu_i_load = ld; exu_i_store = st; exu_i_usign = us; exu_i_size = sz;
        exu_i_rs1 = rs1; exu_i_imm = imm; exu_i_rs2 = rs2; exu_i_rd_idx = rd;
        exu_i_valid = 1'b1;
        step();
        exu_i_valid = 1'b0;
        exu_i_rs1 = $urandom; exu_i_rs2 = $urandom; exu_i_imm = $urandom;
        ea  = rs1 + imm;
        bad = m_bad(ld, st, sz, ea);
        check("exu_ready_busy", exu_o_ready, 0);
        if (!bad) begin
            for (int c = 0; c <= mem_wait; c++) begin
                check("agu_valid", agu_o_valid, 1);
                check("wbck_valid_in_mem", wbck_o_valid, 0);
                check("cmd_addr", agu_o_cmd_addr, ea);
                check("cmd_size", agu_o_cmd_size, sz);
                check("cmd_wmask", agu_o_cmd_wmask, m_mask(sz, ea));
                check("cmd_wdata", agu_o_cmd_wdata, m_wdata(sz, rs2));
                check("cmd_read", agu_o_cmd_read, ld);
                check("cmd_write", agu_o_cmd_write, st);
                check("cmd_usign", agu_o_cmd_usign, us);
                check("cmd_enable", agu_o_cmd_enable, 1);
                check("cmd_misalgn", agu_o_cmd_misalgn, 0);
                check("exu_ready_mem", exu_o_ready, 0);
                if (c == mem_wait) begin
                    agu_i_ready = 1'b1; agu_i_wbck_wdata = rdata; agu_i_wbck_err = merr;
                end
                step();
            end
            agu_i_ready = 1'b0; agu_i_wbck_wdata = $urandom; agu_i_wbck_err = 1'b0;
        end
        for (int c = 0; c <= wb_wait; c++) begin
            check("wbck_valid", wbck_o_valid, 1);
            check("agu_valid_in_wbck", agu_o_valid, 0);
            check("wbck_wdata", wbck_o_wdata, bad ? 32'h0 : (ld ? rdata : 32'h0));
            check("wbck_rd", wbck_o_rd_idx, rd);
            check("wbck_we", wbck_o_we, bad ? 1'b0 : (ld & ~merr));
            check("wbck_err", wbck_o_err, bad ? 1'b1 : merr);
            check("exu_ready_wbck", exu_o_ready, 0);
            if (c == wb_wait) wbck_i_ready = 1'b1;
            step();
        end
        wbck_i_ready = 1'b0;
        check("wbck_valid_done", wbck_o_valid, 0);
        check("exu_ready_done", exu_o_ready, 1);
        $display("txn ld=%0d st=%0d size=%0d addr=%h bad=%0d mw=%0d ww=%0d",
                 ld, st, sz, ea, bad, mem_wait, wb_wait);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic        ld, st;
        logic [31:0] rs1;
        int          op;

        rst = 1'b1; exu_i_valid = 0; exu_i_load = 0; exu_i_store = 0; exu_i_usign = 0;
        exu_i_size = 0; exu_i_rs1 = 0; exu_i_imm = 0; exu_i_rs2 = 0; exu_i_rd_idx = 0;
        agu_i_ready = 0; agu_i_wbck_wdata = 0; agu_i_wbck_err = 0; wbck_i_ready = 0;
        step();
        step();
        check("rst_agu_valid", agu_o_valid, 0);
        check("rst_wbck_valid", wbck_o_valid, 0);
        check("rst_cmd_addr", agu_o_cmd_addr, 0);
        check("rst_cmd_enable", agu_o_cmd_enable, 0);
        check("rst_wbck_wdata", wbck_o_wdata, 0);
        check("rst_wbck_err", wbck_o_err, 0);
        rst = 1'b0;
        step();
        check("rst_exu_ready", exu_o_ready, 1);

        // load word, store byte, misaligned half, back-pressure, address wrap
        run_txn(1, 0, 0, 2'd2, 32'h100, 32'h4, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF, 0);
        run_txn(0, 1, 0, 2'd0, 32'h203, 32'h0, 32'h1234_5678, 5'd7, 0, 0, 32'hCAFE_F00D, 0);
        run_txn(1, 0, 0, 2'd1, 32'h101, 32'h0, 32'h0, 5'd3, 0, 0, 32'h0, 0);
        run_txn(1, 0, 1, 2'd1, 32'h402, 32'h0, 32'hABCD_0000, 5'd9, 3, 2, 32'h0000_8001, 0);
        run_txn(1, 0, 0, 2'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd1, 0, 0, 32'h5555_AAAA, 0);
        run_txn(1, 0, 0, 2'd3, 32'h0, 32'h0, 32'h0, 5'd2, 0, 0, 32'h0, 0);
        run_txn(1, 1, 0, 2'd2, 32'h0, 32'h0, 32'h0, 5'd2, 0, 0, 32'h0, 0);
        run_txn(1, 0, 0, 2'd2, 32'h800, 32'h0, 32'h0, 5'd4, 1, 0, 32'h1111_2222, 1);

        // reset while a command is outstanding
        exu_i_load = 1; exu_i_store = 0; exu_i_size = 2'd2; exu_i_rs1 = 32'h40;
        exu_i_imm = 0; exu_i_rd_idx = 5'd6; exu_i_valid = 1'b1;
        step();
        exu_i_valid = 1'b0;
        check("mem_before_rst", agu_o_valid, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_agu_valid", agu_o_valid, 0);
        step();
        rst = 1'b0;
        agu_i_ready = 1'b1; agu_i_wbck_wdata = 32'h7777_7777;
        step();
        agu_i_ready = 1'b0;
        check("post_rst_exu_ready", exu_o_ready, 1);
        check("post_rst_wbck_valid", wbck_o_valid, 0);
        check("post_rst_agu_valid", agu_o_valid, 0);
        step();
        check("post_rst_wbck_valid2", wbck_o_valid, 0);

`ifdef AGU_BYPASS_EN
        exu_i_load = 1; exu_i_store = 0; exu_i_size = 2'd2; exu_i_rs1 = 32'h1000;
        exu_i_imm = 0; exu_i_rd_idx = 5'd1; exu_i_valid = 1'b1;
        step();
        exu_i_valid = 1'b0;
        agu_i_ready = 1'b1; agu_i_wbck_wdata = 32'h1111_1111;
        step();
        agu_i_ready = 1'b0;
        check("byp_wbck_a", wbck_o_valid, 1);
        check("byp_wdata_a", wbck_o_wdata, 32'h1111_1111);
        wbck_i_ready = 1'b1;
        exu_i_rs1 = 32'h2000; exu_i_rd_idx = 5'd2; exu_i_valid = 1'b1;
        #1 check("byp_ready_in_wbck", exu_o_ready, 1);
        step();
        wbck_i_ready = 1'b0; exu_i_valid = 1'b0;
        check("byp_no_bubble_wbck", wbck_o_valid, 0);
        check("byp_mem_b", agu_o_valid, 1);
        check("byp_addr_b", agu_o_cmd_addr, 32'h2000);
        agu_i_ready = 1'b1; agu_i_wbck_wdata = 32'h2222_2222;
        step();
        agu_i_ready = 1'b0;
        check("byp_wbck_b", wbck_o_valid, 1);
        check("byp_wdata_b", wbck_o_wdata, 32'h2222_2222);
        check("byp_rd_b", wbck_o_rd_idx, 2);
        wbck_i_ready = 1'b1;
        step();
        wbck_i_ready = 1'b0;
        check("byp_idle", exu_o_ready, 1);
        $display("txn bypass back-to-back loads");
`endif

        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 9);
            ld = (op == 1) ? 1'b1 : (op == 0) ? 1'b0 : op[0];
            st = (op == 1) ? 1'b1 : (op == 0) ? 1'b0 : ~op[0];
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rs1 = $urandom;
            if ($urandom_range(0, 2) != 0) rs1[1:0] = 2'b00;
            run_txn(ld, st, 1'($urandom_range(0, 1)), sz, rs1,
                    ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 64)) * 4 : $urandom,
                    $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                    $urandom_range(0, 2), $urandom, ($urandom_range(0, 5) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
